// File: rtl/serial_cmd_pkg.sv
// Shared types and constants for the serial command master: FSM states,
// command opcodes, size limits and the transmit byte selector.
package serial_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEND1  = 3'd1,
        SEND2  = 3'd2,
        RECV   = 3'd3,
        FINISH = 3'd4
    } state_t;

    localparam logic [7:0] OP_VERSION  = 8'd0;
    localparam logic [7:0] OP_COINC    = 8'd1;
    localparam logic [7:0] OP_HISTSEL  = 8'd2;
    localparam logic [7:0] OP_OUTEN    = 8'd3;
    localparam logic [7:0] OP_CLKSW    = 8'd4;
    localparam logic [7:0] OP_PHASE    = 8'd5;
    localparam logic [7:0] OP_SEED     = 8'd6;
    localparam logic [7:0] OP_PRESCALE = 8'd7;
    localparam logic [7:0] OP_ACTCLK   = 8'd8;
    localparam logic [7:0] OP_UPDOWN   = 8'd9;
    localparam logic [7:0] OP_HISTO    = 8'd10;
    localparam logic [7:0] OP_DEAD     = 8'd11;
    localparam logic [7:0] OP_PHASEC1  = 8'd12;
    localparam logic [7:0] OP_ROLL     = 8'd13;

    localparam int MAX_ARGS = 4;
    localparam int MAX_RESP = 32;

    // Index 0 is the opcode, indices 1..4 walk the argument word from its low byte.
    function automatic logic [7:0] tx_byte(input logic [7:0]  opcode,
                                           input logic [31:0] args,
                                           input logic [2:0]  idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = opcode;
            3'd1:    b = args[7:0];
            3'd2:    b = args[15:8];
            3'd3:    b = args[23:16];
            3'd4:    b = args[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/serial_cmd_master_if.sv
// Command, UART and response signal bundle around serial_cmd_master.
// Handshake: cmd_valid/cmd_ready; tx paced by txBusy; rx and resp are strobes.
interface serial_cmd_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_opcode;
    logic [2:0]  cmd_nargs;
    logic [31:0] cmd_args;
    logic [5:0]  cmd_nresp;
    logic        txBusy;
    logic        txStart;
    logic [7:0]  txData;
    logic        rxReady;
    logic [7:0]  rxData;
    logic        resp_valid;
    logic [7:0]  resp_data;
    logic        resp_last;
    logic        done;
    logic        timeout;

    modport master (
        input  cmd_valid, cmd_opcode, cmd_nargs, cmd_args, cmd_nresp,
        input  txBusy, rxReady, rxData,
        output cmd_ready, txStart, txData,
        output resp_valid, resp_data, resp_last, done, timeout
    );

    modport slave (
        output cmd_valid, cmd_opcode, cmd_nargs, cmd_args, cmd_nresp,
        output txBusy, rxReady, rxData,
        input  cmd_ready, txStart, txData,
        input  resp_valid, resp_data, resp_last, done, timeout
    );
endinterface

// File: rtl/serial_cmd_master.sv
// Sends opcode plus up to 4 argument bytes over a UART, then collects up to 32 reply bytes.
// Latency: 2 cycles per transmitted byte minimum; reply bytes appear 1 cycle after rxReady.
// Backpressure: txBusy stalls transmission; cmd_ready only while idle; replies cannot be stalled.
module serial_cmd_master
    import serial_cmd_pkg::*;
#(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_opcode,
    input  logic [2:0]  cmd_nargs,
    input  logic [31:0] cmd_args,
    input  logic [5:0]  cmd_nresp,
    input  logic        txBusy,
    output logic        txStart,
    output logic [7:0]  txData,
    input  logic        rxReady,
    input  logic [7:0]  rxData,
    output logic        resp_valid,
    output logic [7:0]  resp_data,
    output logic        resp_last,
    output logic        done,
    output logic        timeout
);

    state_t      state_q, state_d;
    logic [7:0]  opcode_q, opcode_d;
    logic [31:0] args_q, args_d;
    logic [2:0]  nargs_q, nargs_d;
    logic [5:0]  nresp_q, nresp_d;
    logic [2:0]  idx_q, idx_d;
    logic [5:0]  rcnt_q, rcnt_d;
    logic [23:0] tcnt_q, tcnt_d;
    logic        tx_start_q, tx_start_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        resp_valid_q, resp_valid_d;
    logic [7:0]  resp_data_q, resp_data_d;
    logic        resp_last_q, resp_last_d;
    logic        done_q, done_d;
    logic        timeout_q, timeout_d;

    logic [5:0]  rcnt_nxt;
    logic [23:0] tcnt_nxt;

    // Hold off a new command during the done/timeout pulse so acceptance starts the cycle after.
    assign cmd_ready = (state_q == IDLE) && !done_q && !timeout_q;

    always_comb begin
        rcnt_nxt = (rcnt_q == 6'(MAX_RESP)) ? rcnt_q : rcnt_q + 6'd1;
        tcnt_nxt = tcnt_q + 24'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) state_d = SEND1;
            end
            SEND1: begin
                if (!txBusy) state_d = SEND2;
            end
            SEND2: begin
                if (idx_q < nargs_q)       state_d = SEND1;
                else if (nresp_q != 6'd0)  state_d = RECV;
                else                       state_d = FINISH;
            end
            RECV: begin
                // A byte on the terminal timeout cycle wins over the timeout.
                if (rxReady) begin
                    if (rcnt_nxt == nresp_q) state_d = FINISH;
                end else if (tcnt_nxt == TIMEOUT_CYCLES) begin
                    state_d = IDLE;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        opcode_d     = opcode_q;
        args_d       = args_q;
        nargs_d      = nargs_q;
        nresp_d      = nresp_q;
        idx_d        = idx_q;
        rcnt_d       = rcnt_q;
        tcnt_d       = tcnt_q;
        tx_start_d   = 1'b0;
        tx_data_d    = tx_data_q;
        resp_valid_d = 1'b0;
        resp_data_d  = resp_data_q;
        resp_last_d  = 1'b0;
        done_d       = 1'b0;
        timeout_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    opcode_d = cmd_opcode;
                    args_d   = cmd_args;
                    nargs_d  = (cmd_nargs > 3'(MAX_ARGS)) ? 3'(MAX_ARGS) : cmd_nargs;
                    nresp_d  = (cmd_nresp > 6'(MAX_RESP)) ? 6'(MAX_RESP) : cmd_nresp;
                    idx_d    = 3'd0;
                    rcnt_d   = 6'd0;
                    tcnt_d   = 24'd0;
                end
            end
            SEND1: begin
                if (!txBusy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = tx_byte(opcode_q, args_q, idx_q);
                end
            end
            SEND2: begin
                if (idx_q < nargs_q) begin
                    idx_d = idx_q + 3'd1;
                end else begin
                    rcnt_d = 6'd0;
                    tcnt_d = 24'd0;
                end
            end
            RECV: begin
                if (rxReady) begin
                    resp_valid_d = 1'b1;
                    resp_data_d  = rxData;
                    resp_last_d  = (rcnt_nxt == nresp_q);
                    rcnt_d       = rcnt_nxt;
                    tcnt_d       = 24'd0;
                end else begin
                    tcnt_d    = tcnt_nxt;
                    timeout_d = (tcnt_nxt == TIMEOUT_CYCLES);
                end
            end
            FINISH: begin
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opcode_q     <= 8'h00;
            args_q       <= 32'h0;
            nargs_q      <= 3'd0;
            nresp_q      <= 6'd0;
            idx_q        <= 3'd0;
            rcnt_q       <= 6'd0;
            tcnt_q       <= 24'd0;
            tx_start_q   <= 1'b0;
            tx_data_q    <= 8'h00;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 8'h00;
            resp_last_q  <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            opcode_q     <= opcode_d;
            args_q       <= args_d;
            nargs_q      <= nargs_d;
            nresp_q      <= nresp_d;
            idx_q        <= idx_d;
            rcnt_q       <= rcnt_d;
            tcnt_q       <= tcnt_d;
            tx_start_q   <= tx_start_d;
            tx_data_q    <= tx_data_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_last_q  <= resp_last_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
        end
    end

    assign txStart    = tx_start_q;
    assign txData     = tx_data_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_last  = resp_last_q;
    assign done       = done_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_serial_cmd_master.sv
// Scoreboard bench for serial_cmd_master: directed scenarios plus randomized commands,
// expectations derived from the command/reply rules and checked by an independent monitor.
module tb_serial_cmd_master;
    import serial_cmd_pkg::*;

    logic clk;
    logic reset;
    logic busy_model;
    logic busy_force;

    serial_cmd_master_if ifc ();

    serial_cmd_master #(.TIMEOUT_CYCLES(24'd100)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (ifc.cmd_valid),
        .cmd_ready  (ifc.cmd_ready),
        .cmd_opcode (ifc.cmd_opcode),
        .cmd_nargs  (ifc.cmd_nargs),
        .cmd_args   (ifc.cmd_args),
        .cmd_nresp  (ifc.cmd_nresp),
        .txBusy     (ifc.txBusy),
        .txStart    (ifc.txStart),
        .txData     (ifc.txData),
        .rxReady    (ifc.rxReady),
        .rxData     (ifc.rxData),
        .resp_valid (ifc.resp_valid),
        .resp_data  (ifc.resp_data),
        .resp_last  (ifc.resp_last),
        .done       (ifc.done),
        .timeout    (ifc.timeout)
    );

    assign ifc.txBusy = busy_model | busy_force;

    int checks = 0;
    int errors = 0;
    int tx_seen = 0;
    int resp_seen = 0;
    int end_seen = 0;

    logic [7:0] exp_tx[$];
    logic [8:0] exp_resp[$];   // {last, data}
    logic [1:0] exp_end[$];    // 2'b01 done, 2'b10 timeout
    logic [7:0] reply_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s actual=0x%0h required=none", name, act);
    endtask

    // UART transmitter stand-in: goes busy for 0..3 cycles after each start strobe.
    initial begin
        int n;
        busy_model = 1'b0;
        forever begin
            @(negedge clk);
            if (ifc.txStart) begin
                n = $urandom_range(0, 3);
                @(posedge clk);
                #1;
                if (n > 0) begin
                    busy_model = 1'b1;
                    repeat (n) @(posedge clk);
                    #1;
                    busy_model = 1'b0;
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT emits something.
    initial begin
        int cyc = 0;
        int last_cyc = 0;
        int gap = 0;
        logic prev_busy = 1'b0;
        logic prev_rx = 1'b0;
        logic rdy_chk = 1'b0;
        logic [8:0] er;
        logic [1:0] ee;
        forever begin
            @(negedge clk);
            cyc++;
            if (rdy_chk) begin
                check("ready_after_end", 32'(ifc.cmd_ready), 32'd1);
                rdy_chk = 1'b0;
            end
            if (ifc.txStart) begin
                check("tx_while_busy", 32'(prev_busy), 32'd0);
                if (exp_tx.size() == 0) unexpected("tx_unexpected", 32'(ifc.txData));
                else check("tx_byte", 32'(ifc.txData), 32'(exp_tx.pop_front()));
                tx_seen++;
                last_cyc = cyc;
                gap = 101;
            end
            if (ifc.resp_valid) begin
                check("resp_latency", 32'(prev_rx), 32'd1);
                if (exp_resp.size() == 0) begin
                    unexpected("resp_unexpected", 32'({ifc.resp_last, ifc.resp_data}));
                end else begin
                    er = exp_resp.pop_front();
                    check("resp_last_data", 32'({ifc.resp_last, ifc.resp_data}), 32'(er));
                end
                resp_seen++;
                last_cyc = cyc;
                gap = 100;
            end
            if (ifc.done || ifc.timeout) begin
                if (exp_end.size() == 0) begin
                    unexpected("end_unexpected", 32'({ifc.timeout, ifc.done}));
                end else begin
                    ee = exp_end.pop_front();
                    check("end_kind", 32'({ifc.timeout, ifc.done}), 32'(ee));
                end
                if (ifc.timeout) check("timeout_gap", 32'(cyc - last_cyc), 32'(gap));
                end_seen++;
                rdy_chk = 1'b1;
            end
            prev_busy = ifc.txBusy;
            prev_rx = ifc.rxReady;
        end
    end

    task automatic send_cmd(input logic [7:0] op, input logic [2:0] na,
                            input logic [31:0] ar, input logic [5:0] nr);
        bit got = 0;
        ifc.cmd_valid  = 1'b1;
        ifc.cmd_opcode = op;
        ifc.cmd_nargs  = na;
        ifc.cmd_args   = ar;
        ifc.cmd_nresp  = nr;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (ifc.cmd_ready) begin
                got = 1;
                break;
            end
        end
        if (!got) unexpected("cmd_accept_timeout", 32'd0);
        @(posedge clk);
        #1;
        ifc.cmd_valid = 1'b0;
    endtask

    task automatic wait_tx(input int target);
        bit ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            if (tx_seen >= target) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("tx_wait_expired", 32'(tx_seen), 32'(target));
    endtask

    // Reference: opcode then min(nargs,4) low-first arg bytes; replies up to min(nresp,32);
    // done if every expected reply arrives, otherwise timeout.
    task automatic run_cmd(input logic [7:0] op, input logic [2:0] na, input logic [31:0] ar,
                           input logic [5:0] nr, input bit stray);
        int na_e = (na > 3'd4) ? 4 : int'(na);
        int nr_e = (nr > 6'd32) ? 32 : int'(nr);
        int nrep = reply_q.size();
        int tx_target = tx_seen + 1 + na_e;
        int end_target = end_seen + 1;
        bit ok = 0;
        logic [31:0] sh;
        exp_tx.push_back(op);
        for (int i = 0; i < na_e; i++) begin
            sh = ar >> (8 * i);
            exp_tx.push_back(sh[7:0]);
        end
        for (int i = 0; i < nrep; i++) exp_resp.push_back({(i == nr_e - 1), reply_q[i]});
        exp_end.push_back((nrep == nr_e) ? 2'b01 : 2'b10);
        send_cmd(op, na, ar, nr);
        if (stray) begin
            ifc.rxReady = 1'b1;
            ifc.rxData  = 8'hA5;
            @(posedge clk);
            #1;
            ifc.rxReady = 1'b0;
        end
        wait_tx(tx_target);
        #1;
        for (int i = 0; i < nrep; i++) begin
            ifc.rxReady = 1'b1;
            ifc.rxData  = reply_q[i];
            @(posedge clk);
            #1;
            ifc.rxReady = 1'b0;
            repeat ($urandom_range(0, 4)) begin
                @(posedge clk);
                #1;
            end
        end
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            if (end_seen >= end_target) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("end_wait_expired", 32'(end_seen), 32'(end_target));
        #1;
    endtask

    initial begin
        int base;
        int rs;
        int es;
        logic [7:0] op;
        logic [2:0] na;
        logic [5:0] nr;
        logic [31:0] ar;
        int nr_e;
        int nrep;

        reset = 1'b1;
        busy_force = 1'b0;
        ifc.cmd_valid = 1'b0;
        ifc.cmd_opcode = 8'h00;
        ifc.cmd_nargs = 3'd0;
        ifc.cmd_args = 32'h0;
        ifc.cmd_nresp = 6'd0;
        ifc.rxReady = 1'b0;
        ifc.rxData = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_txStart", 32'(ifc.txStart), 32'd0);
        check("rst_txData", 32'(ifc.txData), 32'd0);
        check("rst_resp_valid", 32'(ifc.resp_valid), 32'd0);
        check("rst_done_timeout", 32'({ifc.done, ifc.timeout, ifc.resp_last}), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_cmd_ready", 32'(ifc.cmd_ready), 32'd1);
        @(posedge clk);
        #1;

        // Version query with one reply byte.
        reply_q.delete();
        reply_q.push_back(8'h07);
        run_cmd(OP_VERSION, 3'd0, 32'h0, 6'd1, 1'b0);

        // Seed with four args, no reply.
        reply_q.delete();
        run_cmd(OP_SEED, 3'd4, 32'hDEADBEEF, 6'd0, 1'b0);

        // Full 32-byte histogram read.
        reply_q.delete();
        for (int i = 0; i < 32; i++) reply_q.push_back(8'(i));
        run_cmd(OP_HISTO, 3'd0, 32'h0, 6'd32, 1'b0);

        // Two replies expected, one arrives.
        reply_q.delete();
        reply_q.push_back(8'h3C);
        run_cmd(OP_COINC, 3'd0, 32'h0, 6'd2, 1'b1);

        // Transmitter held busy for 50 cycles.
        busy_force = 1'b1;
        base = tx_seen;
        reply_q.delete();
        reply_q.push_back(8'h99);
        fork
            run_cmd(OP_OUTEN, 3'd1, 32'h0000_00C3, 6'd1, 1'b0);
            begin
                repeat (50) @(posedge clk);
                check("no_tx_while_forced_busy", 32'(tx_seen), 32'(base));
                #1;
                busy_force = 1'b0;
            end
        join

        // Reset while byte 2 is pending.
        base = tx_seen;
        es = end_seen;
        exp_tx.push_back(OP_PHASE);
        exp_tx.push_back(8'h11);
        exp_tx.push_back(8'h22);
        exp_tx.push_back(8'h33);
        exp_tx.push_back(8'h44);
        send_cmd(OP_PHASE, 3'd4, 32'h44332211, 6'd2);
        wait_tx(base + 2);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_txStart", 32'(ifc.txStart), 32'd0);
        check("midrst_txData", 32'(ifc.txData), 32'd0);
        check("midrst_resp", 32'({ifc.resp_valid, ifc.resp_last, ifc.resp_data}), 32'd0);
        check("midrst_done_timeout", 32'({ifc.done, ifc.timeout}), 32'd0);
        exp_tx.delete();
        exp_resp.delete();
        exp_end.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        rs = resp_seen;
        ifc.rxReady = 1'b1;
        ifc.rxData = 8'h5A;
        @(posedge clk);
        #1;
        ifc.rxReady = 1'b0;
        repeat (150) @(posedge clk);
        #1;
        check("midrst_no_resp", 32'(resp_seen), 32'(rs));
        check("midrst_no_resume_tx", 32'(tx_seen), 32'(base + 2));
        check("midrst_no_end", 32'(end_seen), 32'(es));
        check("midrst_cmd_ready", 32'(ifc.cmd_ready), 32'd1);

        // Randomized commands, including clamped counts, stray bytes and short replies.
        for (int k = 0; k < 25; k++) begin
            op = 8'($urandom_range(0, 13));
            na = 3'($urandom_range(0, 7));
            ar = $urandom;
            nr = 6'($urandom_range(0, 40));
            nr_e = (nr > 6'd32) ? 32 : int'(nr);
            nrep = nr_e;
            if (nr_e > 0 && $urandom_range(0, 4) == 0) nrep = $urandom_range(0, nr_e - 1);
            reply_q.delete();
            for (int i = 0; i < nrep; i++) reply_q.push_back(8'($urandom_range(0, 255)));
            run_cmd(op, na, ar, nr, 1'($urandom_range(0, 1)));
        end

        repeat (5) @(posedge clk);
        check("exp_tx_left", 32'(exp_tx.size()), 32'd0);
        check("exp_resp_left", 32'(exp_resp.size()), 32'd0);
        check("exp_end_left", 32'(exp_end.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_cmd_master.md
SERIAL_CMD_MASTER -- requirements
Module: serial_cmd_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 24'd1000000, the idle-gap limit in clk cycles while awaiting response bytes.
REQ-002 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port cmd_valid  input  1  command request, held until accepted.
REQ-005 SHALL have port cmd_ready  output  1  high only in IDLE; cmd_valid&&cmd_ready accepts the command.
REQ-006 SHALL have port cmd_opcode  input  8  first byte sent.
REQ-007 SHALL have port cmd_nargs  input  3  argument bytes to send, 0..4.
REQ-008 SHALL have port cmd_args  input  32  arguments, byte [7:0] sent first, then [15:8], and so on.
REQ-009 SHALL have port cmd_nresp  input  6  response bytes expected, 0..32.
REQ-010 SHALL have port txBusy  input  1  UART transmitter busy.
REQ-011 SHALL have port txStart  output  1  one-cycle transmit strobe.
REQ-012 SHALL have port txData  output  8  byte to transmit; valid when txStart is high.
REQ-013 SHALL have port rxReady  input  1  one-cycle strobe: UART byte received.
REQ-014 SHALL have port rxData  input  8  received byte.
REQ-015 SHALL have port resp_valid  output  1  one-cycle strobe per response byte.
REQ-016 SHALL have port resp_data  output  8  response byte.
REQ-017 SHALL have port resp_last  output  1  high with the final resp_valid of a command.
REQ-018 SHALL have port done  output  1  one-cycle pulse: command completed normally.
REQ-019 SHALL have port timeout  output  1  one-cycle pulse: command aborted on response timeout.

Function
REQ-020 SHALL implement states IDLE, SEND1, SEND2, RECV, FINISH.
REQ-021 SHALL, on acceptance in IDLE, latch opcode, args, nargs clamped to 4 and nresp clamped to 32, set the byte index to 0, and enter SEND1.
REQ-022 SHALL, in SEND1 with txBusy low, drive txData with the indexed byte (index 0 = opcode, 1..nargs = args) and assert txStart for exactly one cycle, then enter SEND2.
REQ-023 SHALL, in SEND1 with txBusy high, hold without asserting txStart.
REQ-024 SHALL, in SEND2, deassert txStart and, if index < nargs, increment index and enter SEND1; otherwise enter RECV when nresp>0 or FINISH when nresp==0.
REQ-025 SHALL take at least 2 cycles per transmitted byte.
REQ-026 SHALL, in RECV, on each rxReady, present rxData on resp_data with resp_valid the next cycle (latency 1), increment the received count, and clear the timeout counter.
REQ-027 SHALL, in RECV, assert resp_last with the byte that makes the count equal nresp, then enter FINISH.
REQ-028 SHALL, in RECV, increment the timeout counter every cycle without rxReady; on reaching TIMEOUT_CYCLES, pulse timeout and return to IDLE, with no resp_last and no done.
REQ-029 SHALL, in FINISH, pulse done for one cycle and enter IDLE.
REQ-030 SHALL ignore and drop rxReady outside RECV, including bytes arriving during SEND1/SEND2.
REQ-031 SHALL give rxReady priority over the timeout when both occur on the terminal count cycle: the byte is accepted and the counter cleared.
REQ-032 SHALL saturate the received count at 32 with no wrap; the byte counter is 6 bits.
REQ-033 SHALL not accept a new command while busy; cmd_ready is low in all states except IDLE.
REQ-034 SHALL assert cmd_ready again in the cycle after a done or timeout pulse.

Reset
REQ-035 SHALL, on reset assertion at any time including mid-command, enter IDLE immediately.
REQ-036 SHALL, on reset, clear to 0: txStart, txData, resp_valid, resp_data, resp_last, done, timeout, all counters and latched fields; cmd_ready is 1 after release.
REQ-037 SHALL, after reset is released mid-transfer, neither resume nor complete the aborted command.

Structure
REQ-038 SHALL place in shared package serial_cmd_pkg: the state enum and opcode constants OP_VERSION=0, OP_COINC=1, OP_HISTSEL=2, OP_OUTEN=3, OP_CLKSW=4, OP_PHASE=5, OP_SEED=6, OP_PRESCALE=7, OP_ACTCLK=8, OP_UPDOWN=9, OP_HISTO=10, OP_DEAD=11, OP_PHASEC1=12, OP_ROLL=13, and constants MAX_ARGS=4 and MAX_RESP=32.
REQ-039 SHALL be a single module with no sub-module.

Verification
REQ-040 SHALL cover: opcode 0, nargs 0, nresp 1; reply 0x07 -> one txStart with 0x00, then resp_data=0x07 with resp_last=1, done pulse.
REQ-041 SHALL cover: opcode 6, nargs 4, args 0xDEADBEEF, nresp 0 -> txData sequence 06,EF,BE,AD,DE, no resp_valid, done pulse.
REQ-042 SHALL cover: opcode 10, nresp 32, 32 bytes 0x00..0x1F -> 32 resp_valid in order, resp_last only on 0x1F, one done.
REQ-043 SHALL cover: TIMEOUT_CYCLES=100, nresp 2, only 1 byte returned -> timeout pulse 100 cycles after that byte, no done, cmd_ready high next cycle.
REQ-044 SHALL cover: txBusy held high for 50 cycles during nargs 1 -> no txStart while busy, bytes sent in order afterwards.
REQ-045 SHALL cover: reset asserted during SEND1 of byte 2 -> all outputs 0 at once; stray rxReady after release produces no resp_valid.
